multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32 integer datapath: PC, instruction memory, register file, ALU/ALU control and immediate mux.
- Replaces the free-running single-cycle fetch. Each instruction passes through FETCH, DECODE, EXEC and WB.
- Drives PC write, IR load, register write, ALUSrc and ALUOp.
- Handshakes with an instruction memory that may take several cycles to return data.

---
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32 integer datapath.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          instr_i,
  input  logic                 imem_valid_i,
  output logic                 imem_req_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 reg_we_o,
  output logic                 alu_src_o,
  output logic [1:0]           alu_op_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_instr;
  logic [7:0]  r_tmo;
  logic        r_alu_src;
  logic [1:0]  r_alu_op;

  logic w_fetch_ok;
  logic w_tmo_hit;
  logic w_is_halt;
  logic w_is_rtype;
  logic w_is_itype;

  assign w_fetch_ok = (r_state == S_FETCH) && imem_valid_i;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_is_halt  = (r_instr == 32'h0000_0000);
  assign w_is_rtype = (r_instr[6:0] == OP_RTYPE);
  assign w_is_itype = (r_instr[6:0] == OP_ITYPE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_next = S_FETCH;
      // A valid on the final allowed cycle wins over the timeout.
      S_FETCH: begin
        if (imem_valid_i)   w_state_next = S_DECODE;
        else if (w_tmo_hit) w_state_next = S_ERR;
      end
      S_DECODE: begin
        if (w_is_halt)                     w_state_next = S_HALT;
        else if (w_is_rtype || w_is_itype) w_state_next = S_EXEC;
        else                               w_state_next = S_ERR;
      end
      S_EXEC:   w_state_next = S_WB;
      S_WB:     w_state_next = S_FETCH;
      S_HALT:   if (start_i) w_state_next = S_FETCH;
      S_ERR:    if (start_i) w_state_next = S_FETCH;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instr   <= '0;
      r_tmo     <= '0;
      r_alu_src <= 1'b0;
      r_alu_op  <= 2'b00;
    end else begin
      if (w_fetch_ok) begin
        r_instr <= instr_i;
      end
      if ((r_state == S_FETCH) && !imem_valid_i && !w_tmo_hit) begin
        r_tmo <= r_tmo + 8'd1;
      end else begin
        r_tmo <= '0;
      end
      if ((r_state == S_DECODE) && !w_is_halt && w_is_rtype) begin
        r_alu_src <= 1'b0;
        r_alu_op  <= 2'b10;
      end else if ((r_state == S_DECODE) && !w_is_halt && w_is_itype) begin
        r_alu_src <= 1'b1;
        r_alu_op  <= 2'b00;
      end
    end
  end

  // ir_we_o strobes with the accepted word so an external IR captures instr_i
  // on the same edge as the internal copy.
  always_comb begin
    imem_req_o = (r_state == S_FETCH);
    ir_we_o    = w_fetch_ok;
    pc_we_o    = (r_state == S_WB);
    reg_we_o   = (r_state == S_WB);
    busy_o     = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                 (r_state == S_EXEC)  || (r_state == S_WB);
    halted_o   = (r_state == S_HALT);
    err_o      = (r_state == S_ERR);
    alu_src_o  = r_alu_src;
    alu_op_o   = r_alu_op;
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] r_retire_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_retire_cnt <= '0;
    end else if (r_state == S_WB) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign retire_cnt_o = r_retire_cnt;
`else
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected traces built from
// instruction-level rules, directed boundary cases, then a random program.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        imem_valid_i = 1'b0;
  logic        imem_req_o, ir_we_o, pc_we_o, reg_we_o, alu_src_o;
  logic [1:0]  alu_op_o;
  logic        busy_o, halted_o, err_o;
  logic [31:0] retire_cnt_o;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .instr_i(instr_i),
    .imem_valid_i(imem_valid_i), .imem_req_o(imem_req_o), .ir_we_o(ir_we_o),
    .pc_we_o(pc_we_o), .reg_we_o(reg_we_o), .alu_src_o(alu_src_o),
    .alu_op_o(alu_op_o), .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start, valid;
    logic [31:0] instr;
    logic        req, irwe, wb, busy, halted, err, src;
    logic [1:0]  op;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        q[$];
  int          nchk = 0;
  int          nerr = 0;
  int          ntxn = 0;
  logic        m_src = 1'b0;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_cnt = '0;
  int          req_seen, wb_first, wb_count, ir_first, err_seen;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic st, input logic va, input logic [31:0] ins,
                      input logic req, input logic irwe, input logic wb,
                      input logic busy, input logic halted, input logic err);
    cyc_t c;
    c.start = st; c.valid = va; c.instr = ins;
    c.req = req; c.irwe = irwe; c.wb = wb; c.busy = busy;
    c.halted = halted; c.err = err; c.src = m_src; c.op = m_op;
    c.cnt = CNT_ON ? m_cnt : 32'd0;
    q.push_back(c);
  endtask

  // One instruction from the first FETCH cycle; outcome 0=retired 1=halt 2=error.
  task automatic fetch_instr(input logic [31:0] ins, input int wait_n, output int outcome);
    if (wait_n >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) push(rb(), 1'b0, $urandom, 1, 0, 0, 1, 0, 0);
      outcome = 2;
      return;
    end
    for (int i = 0; i < wait_n; i++) push(rb(), 1'b0, $urandom, 1, 0, 0, 1, 0, 0);
    push(rb(), 1'b1, ins, 1, 1, 0, 1, 0, 0);
    push(rb(), rb(), $urandom, 0, 0, 0, 1, 0, 0);
    if (ins == 32'h0) begin
      outcome = 1;
      return;
    end
    if (ins[6:0] == 7'b0110011) begin
      m_src = 1'b0; m_op = 2'b10;
    end else if (ins[6:0] == 7'b0010011) begin
      m_src = 1'b1; m_op = 2'b00;
    end else begin
      outcome = 2;
      return;
    end
    push(rb(), rb(), $urandom, 0, 0, 0, 1, 0, 0);
    push(rb(), rb(), $urandom, 0, 0, 1, 1, 0, 0);
    m_cnt = m_cnt + 32'd1;
    outcome = 0;
  endtask

  // Sit in HALT/ERR for n cycles, then restart.
  task automatic dwell(input int outcome, input int n);
    logic h, e;
    h = (outcome == 1);
    e = (outcome == 2);
    for (int i = 0; i < n; i++) push(1'b0, rb(), $urandom, 0, 0, 0, 0, h, e);
    push(1'b1, rb(), $urandom, 0, 0, 0, 0, h, e);
  endtask

  task automatic play(input int base);
    cyc_t c;
    int   idx;
    idx = base;
    req_seen = 0; wb_first = -1; wb_count = 0; ir_first = -1; err_seen = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      start_i = c.start; imem_valid_i = c.valid; instr_i = c.instr;
      @(negedge clk_i);
      chk("imem_req", idx, 32'(imem_req_o), 32'(c.req));
      chk("ir_we",    idx, 32'(ir_we_o),    32'(c.irwe));
      chk("pc_we",    idx, 32'(pc_we_o),    32'(c.wb));
      chk("reg_we",   idx, 32'(reg_we_o),   32'(c.wb));
      chk("busy",     idx, 32'(busy_o),     32'(c.busy));
      chk("halted",   idx, 32'(halted_o),   32'(c.halted));
      chk("err",      idx, 32'(err_o),      32'(c.err));
      chk("alu_src",  idx, 32'(alu_src_o),  32'(c.src));
      chk("alu_op",   idx, 32'(alu_op_o),   32'(c.op));
      chk("retire",   idx, retire_cnt_o,    c.cnt);
      if (imem_req_o) req_seen++;
      if (err_o) err_seen++;
      if (pc_we_o) begin
        wb_count++;
        if (wb_first < 0) wb_first = idx;
      end
      if (ir_we_o && ir_first < 0) ir_first = idx;
      @(posedge clk_i);
      #1;
      idx++;
    end
    ntxn++;
    $display("txn %0d: cycles=%0d req=%0d wb=%0d retire=%0d", ntxn, idx - base, req_seen, wb_count, retire_cnt_o);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    0, 32'(imem_req_o), 0);
    chk({tag, "_ir_we"},  0, 32'(ir_we_o), 0);
    chk({tag, "_pc_we"},  0, 32'(pc_we_o), 0);
    chk({tag, "_reg_we"}, 0, 32'(reg_we_o), 0);
    chk({tag, "_busy"},   0, 32'(busy_o), 0);
    chk({tag, "_halted"}, 0, 32'(halted_o), 0);
    chk({tag, "_err"},    0, 32'(err_o), 0);
    chk({tag, "_src"},    0, 32'(alu_src_o), 0);
    chk({tag, "_op"},     0, 32'(alu_op_o), 0);
    chk({tag, "_cnt"},    0, retire_cnt_o, 0);
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] w;
    w = $urandom;
    if (kind <= 3) w[6:0] = 7'b0110011;
    else if (kind <= 6) w[6:0] = 7'b0010011;
    else if (kind == 7) w = 32'h0;
    else begin
      for (int k = 0; k < 50; k++) begin
        if (w != 32'h0 && w[6:0] != 7'b0110011 && w[6:0] != 7'b0010011) break;
        w = $urandom;
      end
      if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011 || w == 32'h0) w = 32'h0000_0063;
    end
    return w;
  endfunction

  initial begin
    int oc, kind, wt;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_zero("in_reset");
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    push(1'b0, 1'b1, $urandom, 0, 0, 0, 0, 0, 0);
    push(1'b0, 1'b0, $urandom, 0, 0, 0, 0, 0, 0);
    play(0);

    // addi x1,x0,5 with zero wait
    push(1'b1, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0);
    fetch_instr(32'h00500093, 0, oc);
    play(0);
    chk("addi_ir_cycle", 0, 32'(ir_first), 32'd1);
    chk("addi_wb_cycle", 0, 32'(wb_first), 32'd4);
    chk("addi_wb_count", 0, 32'(wb_count), 32'd1);
    chk("addi_retire",   0, retire_cnt_o, CNT_ON ? 32'd1 : 32'd0);

    // add x3,x1,x2 with valid delayed 3 cycles
    fetch_instr(32'h002081B3, 3, oc);
    play(1);
    chk("add_req_cycles", 0, 32'(req_seen), 32'd4);
    chk("add_wb_cycle",   0, 32'(wb_first), 32'd7);
    chk("add_alu_op",     0, 32'(alu_op_o), 32'd2);

    // Fetch timeout, then valid on the last allowed cycle
    fetch_instr(32'h00500093, TIMEOUT, oc);
    play(1);
    chk("tmo_req_cycles", 0, 32'(req_seen), 32'(TIMEOUT));
    chk("tmo_err",        0, 32'(err_o), 32'd1);
    dwell(2, 3);
    play(0);
    fetch_instr(32'h00500093, TIMEOUT - 1, oc);
    play(1);
    chk("edge_wb_cycle", 0, 32'(wb_first), 32'(TIMEOUT + 3));
    chk("edge_no_err",   0, 32'(err_seen), 32'd0);

    // Illegal opcode, restart, refetch
    fetch_instr(32'h00000063, 1, oc);
    dwell(oc, 4);
    play(1);
    chk("illegal_no_wb", 0, 32'(wb_count), 32'd0);
    fetch_instr(32'h002081B3, 0, oc);
    play(1);

    // Halt word, quiet for 20 cycles
    fetch_instr(32'h0, 0, oc);
    dwell(oc, 20);
    play(1);
    chk("halt_no_wb", 0, 32'(wb_count), 32'd0);
    chk("halt_retire", 0, retire_cnt_o, CNT_ON ? 32'd4 : 32'd0);
    fetch_instr(32'h00500093, 2, oc);
    play(1);

    // Asynchronous reset in the middle of EXEC
    push(1'b0, 1'b1, 32'h002081B3, 1, 1, 0, 1, 0, 0);
    push(1'b0, 1'b0, $urandom, 0, 0, 0, 1, 0, 0);
    play(1);
    start_i = 1'b0; imem_valid_i = 1'b0;
    chk("exec_alu_op", 0, 32'(alu_op_o), 32'd2);
    #3 rst_i = 1'b0;
    #1 chk_all_zero("async_rst");
    m_src = 1'b0; m_op = 2'b00; m_cnt = '0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 5; i++) push(1'b0, rb(), $urandom, 0, 0, 0, 0, 0, 0);
    push(1'b1, 1'b0, $urandom, 0, 0, 0, 0, 0, 0);
    play(0);
    chk("post_rst_no_wb", 0, 32'(wb_count), 32'd0);
    fetch_instr(32'h00500093, 0, oc);
    play(1);

    // Random program
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 8);
      case ($urandom_range(0, 9))
        7:       wt = TIMEOUT - 1;
        8:       wt = TIMEOUT;
        9:       wt = TIMEOUT + 1;
        default: wt = $urandom_range(0, 3);
      endcase
      fetch_instr(rand_instr(kind), wt, oc);
      if (oc != 0) dwell(oc, $urandom_range(0, 3));
      play(1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
